// File: rtl/osram_drain_if.sv
// Bundles the OP SRAM read port, start/busy/done control and the output stream of osram_drain.
// DRAIN_CHECKSUM_EN adds the checksum signal.
interface osram_drain_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] op_addr;
    logic              op_cen;
    logic              op_wen;
    logic [DATA_W-1:0] op_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
`ifdef DRAIN_CHECKSUM_EN
    logic [15:0]       checksum;

    modport master (
        input  start, op_q, out_ready,
        output busy, done, op_addr, op_cen, op_wen, out_data, out_valid, out_last, checksum
    );
    modport slave (
        output start, op_q, out_ready,
        input  busy, done, op_addr, op_cen, op_wen, out_data, out_valid, out_last, checksum
    );
`else
    modport master (
        input  start, op_q, out_ready,
        output busy, done, op_addr, op_cen, op_wen, out_data, out_valid, out_last
    );
    modport slave (
        output start, op_q, out_ready,
        input  busy, done, op_addr, op_cen, op_wen, out_data, out_valid, out_last
    );
`endif
endinterface

// File: rtl/osram_drain.sv
// Drains DEPTH words from the OP SRAM (1-cycle read latency) into a 2-entry buffer and streams them out.
// DRAIN_CHECKSUM_EN adds a 16-bit lane-sum checksum of all handshaked words.
module osram_drain #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    osram_drain_if.master bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int LANES = DATA_W / 16;

    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  rd_ptr, sent;
    logic              inflight, inflight_last;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic              head;
    logic [1:0]        count;
    logic              issue, pop, push, accept, drained;
    logic [2:0]        occ_next;

    assign pop      = (count != 2'd0) && bus.out_ready;
    assign push     = inflight;
    // Occupancy after this cycle, counting the read already in flight.
    assign occ_next = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign accept   = (state == IDLE) && bus.start;
    assign drained  = (count == 2'd0) && !inflight && (sent == PTR_W'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = READ;
            READ:    if (rd_ptr == PTR_W'(DEPTH)) state_nxt = FLUSH;
            FLUSH:   if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        bus.done = 1'b0;
        bus.busy = (state != IDLE);
        case (state)
            READ:    issue = (rd_ptr < PTR_W'(DEPTH)) && (occ_next < 3'd2);
            FLUSH:   bus.done = drained;
            default: ;
        endcase
        bus.op_cen  = !issue;
        bus.op_addr = issue ? rd_ptr[ADDR_W-1:0] : addr_q;
        bus.op_wen  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr        <= '0;
            sent          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            addr_q        <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_ptr == PTR_W'(DEPTH - 1));
            if (issue) addr_q <= rd_ptr[ADDR_W-1:0];
            if (accept) begin
                rd_ptr <= '0;
                sent   <= '0;
            end else begin
                if (issue) rd_ptr <= rd_ptr + 1'b1;
                if (pop)   sent   <= sent + 1'b1;
            end
        end
    end

    // Tail slot is head+count; push and pop may coincide at any count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            head        <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                buf_data[head ^ count[0]] <= bus.op_q;
                buf_last[head ^ count[0]] <= inflight_last;
            end
            if (pop) head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = buf_data[head];
    assign bus.out_last  = buf_last[head] && bus.out_valid;

`ifdef DRAIN_CHECKSUM_EN
    logic [15:0] csum, lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) lane_sum = lane_sum + bus.out_data[16*i +: 16];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       csum <= '0;
        else if (accept) csum <= '0;
        else if (pop)    csum <= csum + lane_sum;
    end

    assign bus.checksum = csum;
`endif

    // The issue rule must keep buffered plus in-flight words within the two slots.
    assert property (@(posedge clk) disable iff (reset)
        ({1'b0, count} + {2'b0, inflight}) <= 3'd2);
endmodule

// File: doc/osram_drain.md
Name: osram_drain

Overview:
- Reads the 16 x 128-bit result words that the corelet writes into the output SRAM (OP) after SFU completion.
- Streams them out on a valid/ready interface toward the host/testbench-facing logic.
- Acts as the read-side counterpart of the corelet's OP write sequence, and shares the same single-port SRAM signalling (active-low cen/wen, 1-cycle read latency).
- Contains a 2-entry output buffer so downstream backpressure never drops SRAM read data.

Parameters:
- DEPTH, 16, number of OP words drained per sequence.
- DATA_W, 128, OP word width (8 lanes x 16-bit psum).
- ADDR_W, 4, OP address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin drain; sampled only in IDLE (typically tied to corelet seq_done)
- busy  output  1  high from accepted start through the done cycle
- done  output  1  one-cycle pulse after the last word handshakes
- op_addr  output  ADDR_W  OP SRAM address
- op_cen  output  1  OP chip enable, active low
- op_wen  output  1  OP write enable, active low; constant 1 (read-only)
- op_q  input  DATA_W  OP read data, valid the cycle after a cen-low cycle
- out_data  output  DATA_W  streamed word
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accept
- out_last  output  1  high with the word read from address DEPTH-1
- checksum  output  16  only present with DRAIN_CHECKSUM_EN

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; clock is clk.
- Reset values: busy=0, done=0, op_addr=0, op_cen=1, op_wen=1, out_valid=0, out_last=0, out_data=0, checksum=0. Reset also clears the read pointer, in-flight flag and buffer count.
- FSM states:
  - IDLE: if start, go to READ; rd_ptr=0, sent=0, busy=1.
  - READ: issues reads until rd_ptr==DEPTH, then goes to FLUSH.
  - FLUSH: waits until buffer empty, nothing in flight, and sent==DEPTH. Then goes to IDLE, pulses done for one cycle, and drops busy on the same edge that returns to IDLE.
- Issue rule (combinational in READ): issue = (rd_ptr < DEPTH) && (count + inflight - pop < 2), where pop = out_valid && out_ready.
  - On issue: op_cen=0 and op_addr=rd_ptr; rd_ptr increments at the next edge.
  - When not issuing: op_cen=1 and op_addr holds its last value.
- Read latency: inflight register is set on issue. At the next edge op_q is written into the buffer tail. The capture edge is the one after the SRAM samples cen, i.e. op_q is registered one cycle after the issue cycle.
- Timing from start: start sampled at edge E0; first cen-low cycle is E0..E1; out_valid rises after E2.
- Throughput: with out_ready held at 1, one word per cycle; the last handshake occurs DEPTH-1 cycles after the first.
- Buffer: 2-entry FIFO.
  - out_data/out_last come from the head.
  - Simultaneous push and pop is legal at any count.
  - Overflow is impossible by the issue rule; an assertion flags count+inflight > 2.
- Output stability: while out_valid && !out_ready, out_data and out_last hold stable.
- done: asserted the cycle after the handshake of the word with out_last=1, but only once the FSM is in FLUSH and empty; this is always the next cycle.
- start while busy is ignored. start in the same cycle done is high is ignored; start is accepted the following cycle.
- out_ready held low indefinitely: at most 2 reads issue past the last pop; rd_ptr stalls and op_cen stays 1.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No done pulse; partial data is discarded.
- op_wen is never 0.

Optional Feature:
- Macro: DRAIN_CHECKSUM_EN.
- Defined:
  - The checksum port exists and is cleared to 0 on accepted start.
  - On each handshake it adds the eight 16-bit lanes of out_data, modulo 2^16 with carries discarded.
  - Its final value is stable from the done cycle until the next accepted start.
- Undefined: the checksum port and its accumulator are absent; all other behaviour is identical.

Test Plan:
- Basic drain: preload OP[i] = {8{16'(i)}}, pulse start, out_ready=1 -> 16 words in consecutive cycles with values 0..15 in every lane; first out_valid 2 edges after start; out_last only on word 15; done one cycle after word 15; busy low afterwards.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> all 16 words in order, no duplicates or losses; out_data stable during stalls; op_cen low never exceeds 2 reads ahead of pops.
- Long stall: out_ready=0 for 50 cycles after start, then 1 -> exactly 2 cen-low cycles (addresses 0,1) during the stall, then 16 words in order.
- start during busy: second start pulse at word 5 -> ignored; exactly 16 words and one done. start pulsed the cycle after done -> a fresh sequence of 16 words.
- Reset mid-drain: assert reset after word 7 handshakes -> all outputs at reset values the same cycle; no done. A new start drains from address 0.
- Checksum (DRAIN_CHECKSUM_EN): OP[i] lanes = 16'h1000 + i -> checksum at done = (16*8*16'h1000 + 8*120) mod 2^16 = 16'h03C0.
